// File: rtl/dl_wr_arb.sv
// Write-port controller for the dl gated-latch bank: arbitrates requesters and drives a
// setup / open / hold gate sequence. Define DL_ARB_RR_EN for round-robin arbitration.
module dl_wr_arb #(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 8,
  parameter  int OPEN_CYC = 2,
  localparam int SW       = $clog2(N_REQ),
  localparam int CW       = $clog2(OPEN_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] d,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                lat_en,
  output logic [DW-1:0]       lat_d,
  output logic [SW-1:0]       lat_sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              lat_en_q, lat_en_d;
  logic [DW-1:0]     lat_d_q, lat_d_d;
  logic [SW-1:0]     lat_sel_q, lat_sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              any_req;
  logic [SW-1:0]     win;

`ifdef DL_ARB_RR_EN
  logic [SW-1:0]     ptr_q, ptr_d;
  logic              found;
  int                idx;

  // Search begins just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    any_req = |req;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + 1 + i) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index as the winner.
  always_comb begin
    any_req = |req;
    win     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = SW'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    lat_en_d  = 1'b0;
    lat_d_d   = lat_d_q;
    lat_sel_d = lat_sel_q;
    cnt_d     = cnt_q;
`ifdef DL_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (any_req) begin
          lat_d_d   = d[int'(win)*DW +: DW];
          lat_sel_d = win;
          gnt_d     = N_REQ'(1) << win;
          state_d   = S_SETUP;
`ifdef DL_ARB_RR_EN
          ptr_d     = win;
`endif
        end
      end
      S_SETUP: begin
        lat_en_d = 1'b1;
        cnt_d    = '0;
        state_d  = S_OPEN;
      end
      S_OPEN: begin
        // The gate closes one edge before data may move, giving the hold cycle.
        if (cnt_q == CW'(OPEN_CYC - 1)) begin
          cnt_d   = '0;
          done_d  = gnt_q;
          state_d = S_HOLD;
        end else begin
          lat_en_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset wins over everything, including an open gate, so an aborted write never completes.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      lat_en_q  <= 1'b0;
      lat_d_q   <= '0;
      lat_sel_q <= '0;
      cnt_q     <= '0;
`ifdef DL_ARB_RR_EN
      ptr_q     <= SW'(N_REQ - 1);
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      lat_en_q  <= lat_en_d;
      lat_d_q   <= lat_d_d;
      lat_sel_q <= lat_sel_d;
      cnt_q     <= cnt_d;
`ifdef DL_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign lat_en  = lat_en_q;
  assign lat_d   = lat_d_q;
  assign lat_sel = lat_sel_q;

  // Protocol invariants of the latch write path.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_done_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
  a_done_in_hold : assert property (@(posedge clk) disable iff (rst)
    (done_q != '0) |-> (state_q == S_HOLD));
  a_gate_data_stable : assert property (@(posedge clk) disable iff (rst)
    lat_en_q |-> ($stable(lat_d_q) && $stable(lat_sel_q)));
  a_gnt_during_gate : assert property (@(posedge clk) disable iff (rst)
    lat_en_q |-> (gnt_q != '0));

endmodule

// File: tb/tb_dl_wr_arb.sv
// Directed bench for dl_wr_arb (N_REQ=4, DW=8, OPEN_CYC=2); round-robin checks apply
// when DL_ARB_RR_EN is defined, fixed-priority checks otherwise.
module tb_dl_wr_arb;
  localparam int N_REQ    = 4;
  localparam int DW       = 8;
  localparam int OPEN_CYC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] d;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        lat_en;
  logic [7:0]  lat_d;
  logic [1:0]  lat_sel;
  logic [18:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  dl_wr_arb #(.N_REQ(N_REQ), .DW(DW), .OPEN_CYC(OPEN_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .done    (done),
    .lat_en  (lat_en),
    .lat_d   (lat_d),
    .lat_sel (lat_sel)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, done, lat_en, lat_d, lat_sel};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    d   = 32'hDEAD_BEEF;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++;
    if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
    n_checks++;
    if (lat_en !== 1'b0) begin n_fail++; $display("FAIL reset_lat_en: got %b expected 0", lat_en); end
    n_checks++;
    if (lat_d !== 8'h00) begin n_fail++; $display("FAIL reset_lat_d: got %h expected 00", lat_d); end
    n_checks++;
    if (lat_sel !== 2'd0) begin n_fail++; $display("FAIL reset_lat_sel: got %0d expected 0", lat_sel); end
    req = 4'b0000;
    d   = '0;
    rst = 1'b0;
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_gnt: got %b expected 0000", gnt); end
  endtask

  task automatic test_single();
    logic [18:0] exp;
    d      = '0;
    d[7:0] = 8'hA5;
    req    = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp = {((c <= 4) ? 4'b0001 : 4'b0000), ((c == 4) ? 4'b0001 : 4'b0000),
             ((c == 2) || (c == 3)), 8'hA5, 2'd0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL single c%0d: got %h expected %h", c, obs, exp); end
      if (c == 4) req = 4'b0000;
    end
  endtask

`ifndef DL_ARB_RR_EN
  task automatic test_fixed_prio();
    logic [18:0] exp;
    d   = {8'h43, 8'h32, 8'h21, 8'h10};
    req = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      for (int c = 1; c <= 5; c++) begin
        step();
        exp = {((c <= 4) ? 4'b0010 : 4'b0000), ((c == 4) ? 4'b0010 : 4'b0000),
               ((c == 2) || (c == 3)), 8'h21, 2'd1};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL fixed_prio t%0d c%0d: got %h expected %h", t, c, obs, exp); end
      end
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL fixed_prio_end: got %b expected 0000", gnt); end
  endtask
`else
  task automatic test_round_robin();
    logic [18:0] exp;
    logic [3:0]  oh;
    logic [1:0]  w;
    do_reset();
    d   = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w  = 2'(t % 4);
      oh = 4'b0001 << w;
      for (int c = 1; c <= 5; c++) begin
        step();
        exp = {((c <= 4) ? oh : 4'b0000), ((c == 4) ? oh : 4'b0000),
               ((c == 2) || (c == 3)), 8'h10 + 8'(w), w};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL round_robin t%0d c%0d: got %h expected %h", t, c, obs, exp); end
      end
    end
    req = 4'b0000;
  endtask
`endif

  task automatic test_data_stable();
    logic [18:0] exp;
    d      = '0;
    d[7:0] = 8'h3C;
    req    = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp = {((c <= 4) ? 4'b0001 : 4'b0000), ((c == 4) ? 4'b0001 : 4'b0000),
             ((c == 2) || (c == 3)), 8'h3C, 2'd0};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL data_stable c%0d: got %h expected %h", c, obs, exp); end
      if (c == 1) begin
        d[7:0] = 8'hFF;
        req    = 4'b0000;
      end
    end
  endtask

  task automatic test_reset_mid_open();
    logic [18:0] exp;
    bit          seen;
    d        = '0;
    d[23:16] = 8'h5A;
    req      = 4'b0100;
    step();
    step();
    exp = {4'b0100, 4'b0000, 1'b1, 8'h5A, 2'd2};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL rst_open_pre: got %h expected %h", obs, exp); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (obs !== 19'h0) begin n_fail++; $display("FAIL rst_open_abort: got %h expected %h", obs, 19'h0); end
    seen = 1'b0;
    for (int e = 1; e <= 3 && !seen; e++) begin
      step();
      n_checks++;
      if (done !== 4'b0000) begin n_fail++; $display("FAIL rst_open_no_done e%0d: got %b expected 0000", e, done); end
      if (gnt !== 4'b0000) seen = 1'b1;
    end
    n_checks++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL rst_open_regrant: got %b expected 0100", gnt); end
    for (int c = 2; c <= 5; c++) begin
      step();
      exp = {((c <= 4) ? 4'b0100 : 4'b0000), ((c == 4) ? 4'b0100 : 4'b0000),
             ((c == 2) || (c == 3)), 8'h5A, 2'd2};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL rst_open_txn c%0d: got %h expected %h", c, obs, exp); end
      if (c == 4) req = 4'b0000;
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp;
    logic [3:0]  oh;
    logic [1:0]  w;
    logic [1:0]  w2;
    int          t;
    int          cc;
    int          last_high;
    bit          prev_en;
`ifdef DL_ARB_RR_EN
    w2 = 2'd1;
`else
    w2 = 2'd0;
`endif
    do_reset();
    d         = '0;
    d[7:0]    = 8'hA0;
    d[15:8]   = 8'hB1;
    req       = 4'b0011;
    last_high = -1;
    prev_en   = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      t  = (c <= 5) ? 0 : 1;
      cc = c - 5 * t;
      w  = (t == 0) ? 2'd0 : w2;
      oh = 4'b0001 << w;
      exp = {((cc <= 4) ? oh : 4'b0000), ((cc == 4) ? oh : 4'b0000),
             ((cc == 2) || (cc == 3)), ((w == 2'd0) ? 8'hA0 : 8'hB1), w};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL back_to_back c%0d: got %h expected %h", c, obs, exp); end
      if (lat_en && !prev_en && last_high >= 0) begin
        n_checks++;
        if (c - last_high - 1 < 2) begin
          n_fail++;
          $display("FAIL back_to_back_gap: got %0d low cycles expected at least 2", c - last_high - 1);
        end
      end
      if (lat_en) last_high = c;
      prev_en = lat_en;
      if (c == 9) req = 4'b0000;
    end
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL back_to_back_end: got %b expected 0000", gnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = '0;
    d   = '0;
    test_reset();
    test_single();
`ifdef DL_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_prio();
`endif
    test_data_stable();
    test_reset_mid_open();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
